// File: rtl/escalonador_somador_if.sv
// rtl/escalonador_somador_if.sv - request and result bus of the shared adder scheduler
// slave is the scheduler side, master is the requesters/consumer side.
interface escalonador_somador_if #(
  parameter int LARGURA_CONT = 16
);
  logic                    valido_0;
  logic                    pronto_0;
  logic [7:0]              a_0;
  logic [3:0]              b_0;
  logic [1:0]              codigo_0;
  logic                    valido_1;
  logic                    pronto_1;
  logic [7:0]              a_1;
  logic [3:0]              b_1;
  logic [1:0]              codigo_1;
  logic                    saida_valida;
  logic                    saida_pronta;
  logic [7:0]              saida;
  logic                    saida_id;
  logic                    saida_overflow;
  logic [LARGURA_CONT-1:0] contador_ops;

  modport slave (
    input  valido_0, a_0, b_0, codigo_0,
    input  valido_1, a_1, b_1, codigo_1,
    input  saida_pronta,
    output pronto_0, pronto_1,
    output saida_valida, saida, saida_id, saida_overflow, contador_ops
  );

  modport master (
    output valido_0, a_0, b_0, codigo_0,
    output valido_1, a_1, b_1, codigo_1,
    output saida_pronta,
    input  pronto_0, pronto_1,
    input  saida_valida, saida, saida_id, saida_overflow, contador_ops
  );
endinterface

// File: rtl/escalonador_somador.sv
// rtl/escalonador_somador.sv - round-robin scheduler sharing one registered mixed-sign adder
// Two valid/ready requesters, one single-entry result register with valid/ready.
module escalonador_somador #(
  parameter bit PRIORIDADE_INICIAL = 1'b0,
  parameter int LARGURA_CONT       = 16
) (
  input logic                  clk,
  input logic                  rst,
  escalonador_somador_if.slave bus
);

  logic                    saida_valida_q, saida_valida_d;
  logic [7:0]              saida_q, saida_d;
  logic                    saida_id_q, saida_id_d;
  logic                    saida_overflow_q, saida_overflow_d;
  logic                    ultimo_q, ultimo_d;
  logic [LARGURA_CONT-1:0] contador_q, contador_d;

  logic       livre;
  logic       conc_0, conc_1, transf;
  logic [7:0] a_sel;
  logic [3:0] b_sel;
  logic [1:0] cod_sel;
  logic [8:0] soma_s, soma_u;
  logic       ovf_s;
  logic [7:0] res;
  logic       ovf;

  always_comb livre = !saida_valida_q || bus.saida_pronta;

  // On conflict, serve whoever was not served last.
  always_comb begin
    conc_0 = 1'b0;
    conc_1 = 1'b0;
    if (!rst && livre) begin
      if (bus.valido_0 && bus.valido_1) begin
        conc_0 = ultimo_q;
        conc_1 = !ultimo_q;
      end else begin
        conc_0 = bus.valido_0;
        conc_1 = bus.valido_1;
      end
    end
  end

  assign bus.pronto_0 = conc_0;
  assign bus.pronto_1 = conc_1;

  always_comb transf = conc_0 || conc_1;

  always_comb begin
    a_sel   = bus.a_0;
    b_sel   = bus.b_0;
    cod_sel = bus.codigo_0;
    if (conc_1) begin
      a_sel   = bus.a_1;
      b_sel   = bus.b_1;
      cod_sel = bus.codigo_1;
    end
  end

  // 9-bit sums are exact; signed overflow shows up as bit 8 differing from bit 7.
  always_comb begin
    soma_s = {a_sel[7], a_sel} + {{5{b_sel[3]}}, b_sel};
    soma_u = {1'b0, a_sel} + {5'b00000, b_sel};
    ovf_s  = soma_s[8] ^ soma_s[7];
    res    = soma_s[7:0];
    ovf    = ovf_s;
    case (cod_sel)
      2'b00: begin
        res = soma_s[7:0];
        ovf = ovf_s;
      end
      2'b01: begin
        res = soma_u[7:0];
        ovf = soma_u[8];
      end
      2'b10: begin
        res = ovf_s ? (soma_s[8] ? 8'h80 : 8'h7F) : soma_s[7:0];
        ovf = ovf_s;
      end
      default: begin
        res = soma_u[8] ? 8'hFF : soma_u[7:0];
        ovf = soma_u[8];
      end
    endcase
  end

  always_comb begin
    saida_valida_d   = saida_valida_q;
    saida_d          = saida_q;
    saida_id_d       = saida_id_q;
    saida_overflow_d = saida_overflow_q;
    ultimo_d         = ultimo_q;
    contador_d       = contador_q;
    if (transf) begin
      saida_valida_d   = 1'b1;
      saida_d          = res;
      saida_id_d       = conc_1;
      saida_overflow_d = ovf;
      ultimo_d         = conc_1;
      contador_d       = contador_q + {{(LARGURA_CONT-1){1'b0}}, 1'b1};
    end else if (bus.saida_pronta) begin
      saida_valida_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      saida_valida_q   <= 1'b0;
      saida_q          <= 8'h00;
      saida_id_q       <= 1'b0;
      saida_overflow_q <= 1'b0;
      ultimo_q         <= ~PRIORIDADE_INICIAL;
      contador_q       <= '0;
    end else begin
      saida_valida_q   <= saida_valida_d;
      saida_q          <= saida_d;
      saida_id_q       <= saida_id_d;
      saida_overflow_q <= saida_overflow_d;
      ultimo_q         <= ultimo_d;
      contador_q       <= contador_d;
    end
  end

  assign bus.saida_valida   = saida_valida_q;
  assign bus.saida          = saida_q;
  assign bus.saida_id       = saida_id_q;
  assign bus.saida_overflow = saida_overflow_q;
  assign bus.contador_ops   = contador_q;

endmodule

// File: tb/tb_escalonador_somador.sv
// tb/tb_escalonador_somador.sv - self-checking bench for escalonador_somador
// Vector table, directed sequences and random traffic against an integer reference model.
module tb_escalonador_somador;
  localparam int LC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  escalonador_somador_if #(.LARGURA_CONT(LC)) bus ();

  escalonador_somador #(
    .PRIORIDADE_INICIAL(1'b0),
    .LARGURA_CONT(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic          m_valid, m_id, m_ovf, m_last;
  logic [7:0]    m_saida;
  logic [LC-1:0] m_cnt;
  logic [9:0]    sb[$];
  logic          acc0, acc1;

  typedef struct {
    bit         req;
    logic [7:0] a;
    logic [3:0] b;
    logic [1:0] cod;
    logic [7:0] esp;
    bit         ovf;
  } vec_t;
  vec_t tab[10];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] esp);
    total++;
    if (got !== esp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nome, got, esp);
    end
  endtask

  // Reference arithmetic from integer values of the operands.
  function automatic logic [8:0] ref_op(input logic [7:0] a, input logic [3:0] b, input logic [1:0] c);
    int sa, sb_, ua, ub, s;
    logic [7:0] r;
    logic o;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= 128) ? ua - 256 : ua;
    sb_ = (ub >= 8) ? ub - 16 : ub;
    case (c)
      2'b00: begin s = sa + sb_; r = s[7:0]; o = (s > 127) || (s < -128); end
      2'b01: begin s = ua + ub;  r = s[7:0]; o = (s > 255); end
      2'b10: begin
        s = sa + sb_;
        if (s > 127) begin r = 8'h7F; o = 1'b1; end
        else if (s < -128) begin r = 8'h80; o = 1'b1; end
        else begin r = s[7:0]; o = 1'b0; end
      end
      default: begin
        s = ua + ub;
        if (s > 255) begin r = 8'hFF; o = 1'b1; end
        else begin r = s[7:0]; o = 1'b0; end
      end
    endcase
    return {o, r};
  endfunction

  task automatic ciclo();
    logic livre, g0, g1;
    logic [8:0] r;
    logic [9:0] e;
    @(negedge clk);
    livre = !m_valid || bus.saida_pronta;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst && livre) begin
      if (bus.valido_0 && !bus.valido_1) g0 = 1'b1;
      else if (bus.valido_1 && !bus.valido_0) g1 = 1'b1;
      else if (bus.valido_0 && bus.valido_1) begin
        if (m_last) g0 = 1'b1;
        else g1 = 1'b1;
      end
    end
    check("pronto", {30'd0, bus.pronto_1, bus.pronto_0}, {30'd0, g1, g0});
    if (!rst && bus.saida_valida && bus.saida_pronta) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got result id=%0d saida=%0h expected=none", bus.saida_id, bus.saida);
      end else begin
        e = sb.pop_front();
        check("sb_consumo", {22'd0, bus.saida_id, bus.saida_overflow, bus.saida}, {22'd0, e});
      end
    end
    if (rst) begin
      m_valid = 1'b0; m_saida = 8'h00; m_id = 1'b0; m_ovf = 1'b0; m_cnt = '0; m_last = 1'b1;
      sb.delete();
    end else if (g0 || g1) begin
      r = g1 ? ref_op(bus.a_1, bus.b_1, bus.codigo_1) : ref_op(bus.a_0, bus.b_0, bus.codigo_0);
      m_valid = 1'b1; m_saida = r[7:0]; m_ovf = r[8]; m_id = g1; m_last = g1;
      m_cnt = m_cnt + 1'b1;
      sb.push_back({g1, r});
    end else if (bus.saida_pronta) begin
      m_valid = 1'b0;
    end
    acc0 = bus.pronto_0;
    acc1 = bus.pronto_1;
    @(posedge clk);
    #1;
    check("saidas", {17'd0, bus.saida_valida, bus.saida_id, bus.saida_overflow, bus.saida, bus.contador_ops},
          {17'd0, m_valid, m_id, m_ovf, m_saida, m_cnt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ciclo();
    rst = 1'b0;
  endtask

  task automatic drive_random();
    if (!bus.valido_0 || acc0) begin
      bus.valido_0 = ($urandom_range(3) != 0);
      bus.a_0 = 8'($urandom); bus.b_0 = 4'($urandom); bus.codigo_0 = 2'($urandom);
    end
    if (!bus.valido_1 || acc1) begin
      bus.valido_1 = ($urandom_range(3) != 0);
      bus.a_1 = 8'($urandom); bus.b_1 = 4'($urandom); bus.codigo_1 = 2'($urandom);
    end
    bus.saida_pronta = ($urandom_range(3) != 0);
    rst = ($urandom_range(99) == 0);
  endtask

  logic [7:0] held_saida;
  logic       held_id;

  initial begin
    tab[0] = '{1'b0, 8'h01, 4'h1, 2'b00, 8'h02, 1'b0};
    tab[1] = '{1'b1, 8'h7F, 4'h1, 2'b00, 8'h80, 1'b1};
    tab[2] = '{1'b1, 8'h7F, 4'h1, 2'b10, 8'h7F, 1'b1};
    tab[3] = '{1'b1, 8'h03, 4'hF, 2'b00, 8'h02, 1'b0};
    tab[4] = '{1'b1, 8'h03, 4'hF, 2'b01, 8'h12, 1'b0};
    tab[5] = '{1'b1, 8'h80, 4'h8, 2'b10, 8'h80, 1'b1};
    tab[6] = '{1'b1, 8'hFA, 4'hF, 2'b01, 8'h09, 1'b1};
    tab[7] = '{1'b1, 8'hFA, 4'hF, 2'b11, 8'hFF, 1'b1};
    tab[8] = '{1'b0, 8'h80, 4'h8, 2'b00, 8'h78, 1'b1};
    tab[9] = '{1'b0, 8'h05, 4'hF, 2'b11, 8'h14, 1'b0};

    bus.valido_0 = 1'b0; bus.a_0 = 8'h00; bus.b_0 = 4'h0; bus.codigo_0 = 2'b00;
    bus.valido_1 = 1'b0; bus.a_1 = 8'h00; bus.b_1 = 4'h0; bus.codigo_1 = 2'b00;
    bus.saida_pronta = 1'b1;
    m_valid = 1'b0; m_saida = 8'h00; m_id = 1'b0; m_ovf = 1'b0; m_cnt = '0; m_last = 1'b1;
    acc0 = 1'b0; acc1 = 1'b0;

    do_reset();
    check("reset_state", {17'd0, bus.saida_valida, bus.saida_id, bus.saida_overflow, bus.saida, bus.contador_ops}, 32'd0);

    for (int k = 0; k < 10; k++) begin
      bus.valido_0 = !tab[k].req;
      bus.valido_1 = tab[k].req;
      if (tab[k].req) begin
        bus.a_1 = tab[k].a; bus.b_1 = tab[k].b; bus.codigo_1 = tab[k].cod;
      end else begin
        bus.a_0 = tab[k].a; bus.b_0 = tab[k].b; bus.codigo_0 = tab[k].cod;
      end
      ciclo();
      check($sformatf("vec%0d", k), {21'd0, bus.saida_valida, bus.saida_id, bus.saida_overflow, bus.saida},
            {21'd0, 1'b1, tab[k].req, tab[k].ovf, tab[k].esp});
      check($sformatf("vec%0d_cnt", k), 32'(bus.contador_ops), 32'(k + 1));
    end
    bus.valido_0 = 1'b0;
    bus.valido_1 = 1'b0;
    ciclo();
    check("consume_idle", {31'd0, bus.saida_valida}, 32'd0);

    // Fairness: both requesting every cycle alternate starting with requester 0.
    do_reset();
    bus.valido_0 = 1'b1; bus.a_0 = 8'h10; bus.b_0 = 4'h1; bus.codigo_0 = 2'b01;
    bus.valido_1 = 1'b1; bus.a_1 = 8'h20; bus.b_1 = 4'h2; bus.codigo_1 = 2'b01;
    for (int k = 0; k < 6; k++) begin
      ciclo();
      check($sformatf("rr_id%0d", k), {30'd0, bus.saida_valida, bus.saida_id}, {30'd0, 1'b1, 1'(k % 2)});
    end
    check("rr_cnt", 32'(bus.contador_ops), 32'd6);

    // Backpressure holds everything.
    held_saida = bus.saida;
    held_id    = bus.saida_id;
    bus.saida_pronta = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ciclo();
      check("bp_pronto", {30'd0, bus.pronto_1, bus.pronto_0}, 32'd0);
      check("bp_hold", {23'd0, bus.saida_id, bus.saida}, {23'd0, held_id, held_saida});
      check("bp_cnt", 32'(bus.contador_ops), 32'd6);
    end
    bus.saida_pronta = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ciclo();
      check($sformatf("bp_resume%0d", k), {31'd0, bus.saida_id}, {31'd0, 1'(k % 2)});
    end
    check("bp_cnt_after", 32'(bus.contador_ops), 32'd10);

    // Reset while a result is held under backpressure.
    bus.saida_pronta = 1'b0;
    ciclo();
    rst = 1'b1;
    ciclo();
    rst = 1'b0;
    check("rst_mid", {17'd0, bus.saida_valida, bus.saida, bus.contador_ops, 2'b00}, 32'd0);
    bus.saida_pronta = 1'b1;
    ciclo();
    check("rst_first_grant", {30'd0, bus.saida_valida, bus.saida_id}, {30'd0, 1'b1, 1'b0});

    // Counter wrap.
    do_reset();
    bus.valido_1 = 1'b0;
    bus.valido_0 = 1'b1;
    for (int k = 0; k < 16; k++) ciclo();
    check("wrap_zero", 32'(bus.contador_ops), 32'd0);
    ciclo();
    check("wrap_one", 32'(bus.contador_ops), 32'd1);

    do_reset();
    for (int k = 0; k < 500; k++) begin
      drive_random();
      ciclo();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
